// File: rtl/image_scan_reader.sv
// Raster-order read sequencer for image_rom.
// Hides the ROM read latency behind a 2-deep skid buffer.
module image_scan_reader #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int ROW_W = 8,
  parameter int COL_W = 9,
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [PIX_W-1:0] rom_data,
  output logic [PIX_W-1:0] pix_data,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             pix_valid,
  input  logic             pix_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             sof;
    logic             eol;
    logic             eof;
  } meta_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    meta_t            meta;
  } ent_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             done_q;
  logic             inf_q;
  meta_t            inf_meta_q;
  ent_t             e0_q, e0_d;
  ent_t             e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic       last;
  logic [2:0] occ;
  meta_t      cur;
  ent_t       new_e;

  assign pop   = (cnt_q != 2'd0) & pix_ready;
  assign push  = inf_q;
  assign occ   = 3'(cnt_q) + 3'(inf_q) - 3'(pop);
  assign issue = (state_q == SCAN) && (occ < 3'd2);
  assign last  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign cur.row = row_q;
  assign cur.col = col_q;
  assign cur.sof = (row_q == '0) && (col_q == '0);
  assign cur.eol = (col_q == COL_LAST);
  assign cur.eof = last;

  assign new_e.data = rom_data;
  assign new_e.meta = inf_meta_q;

  // Slot 0 is always the head; slot 1 only fills behind a stalled head.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = new_e;
        end else begin
          e0_d = e1_q;
          e1_d = new_e;
        end
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = new_e;
        else               e1_d = new_e;
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      cnt_q      <= 2'd0;
      inf_q      <= 1'b0;
      inf_meta_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
      inf_q <= issue;
      if (issue) inf_meta_q <= cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        SCAN: begin
          if (issue) begin
            if (last) begin
              state_q <= DRAIN;
            end else if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!inf_q && cnt_d == 2'd0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rom_row   = row_q;
  assign rom_col   = col_q;
  assign pix_data  = e0_q.data;
  assign pix_row   = e0_q.meta.row;
  assign pix_col   = e0_q.meta.col;
  assign pix_sof   = e0_q.meta.sof;
  assign pix_eol   = e0_q.meta.eol;
  assign pix_eof   = e0_q.meta.eof;
  assign pix_valid = (cnt_q != 2'd0);

endmodule

// File: tb/tb_image_scan_reader.sv
// Bench for image_scan_reader: 4x3, 320x5 and 1x1 frames
// checked against a raster-index model of the pixel stream.
module tb_image_scan_reader;

  function automatic int img_w(input int k);
    return (k == 0) ? 4 : (k == 1) ? 320 : 1;
  endfunction

  function automatic int img_h(input int k);
    return (k == 0) ? 3 : (k == 1) ? 5 : 1;
  endfunction

  function automatic logic [11:0] rom_f(input logic [7:0] r,
                                        input logic [8:0] c);
    return 12'({r, c});
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [3];
  logic        start_s [3];
  logic        ready_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [7:0]  rrow_s  [3];
  logic [8:0]  rcol_s  [3];
  logic [11:0] rom_s   [3];
  logic [11:0] pdat_s  [3];
  logic [7:0]  prow_s  [3];
  logic [8:0]  pcol_s  [3];
  logic        sof_s   [3];
  logic        eol_s   [3];
  logic        eof_s   [3];
  logic        val_s   [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    image_scan_reader #(
      .IMG_W(img_w(g)),
      .IMG_H(img_h(g))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_s[g]),
      .start    (start_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .rom_row  (rrow_s[g]),
      .rom_col  (rcol_s[g]),
      .rom_data (rom_s[g]),
      .pix_data (pdat_s[g]),
      .pix_row  (prow_s[g]),
      .pix_col  (pcol_s[g]),
      .pix_sof  (sof_s[g]),
      .pix_eol  (eol_s[g]),
      .pix_eof  (eof_s[g]),
      .pix_valid(val_s[g]),
      .pix_ready(ready_s[g])
    );

    always @(posedge clk) rom_s[g] <= rom_f(rrow_s[g], rcol_s[g]);
  end

  // mode 0: ready always high, cycle-exact timing checked
  // mode 1: ready low in cycles 4..8
  // mode 2: ready random 50%
  task automatic run_frame(input int k, input int mode, input bit spam);
    int w;
    int n;
    int cyc;
    int idx;
    int last_hs;
    int budget;
    bit fin;
    logic [7:0] er;
    logic [8:0] ec;
    w = img_w(k);
    n = w * img_h(k);
    checks++;
    if (busy_s[k] !== 1'b0 || val_s[k] !== 1'b0 || done_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start k=%0d busy=%b valid=%b done=%b required 0 0 0",
               k, busy_s[k], val_s[k], done_s[k]);
    end
    start_s[k] = 1'b1;
    ready_s[k] = 1'b1;
    @(negedge clk);
    cyc = 1;
    idx = 0;
    last_hs = -1;
    fin = 1'b0;
    budget = 4 * n + 40;
    while (!fin && cyc < budget) begin
      start_s[k] = spam && busy_s[k];
      if (mode == 0) ready_s[k] = 1'b1;
      else if (mode == 1) ready_s[k] = !(cyc >= 4 && cyc <= 8);
      else ready_s[k] = 1'($urandom_range(0, 1));
      if (mode == 1 && cyc >= 4 && cyc <= 8) begin
        checks++;
        if (val_s[k] !== 1'b1 || pdat_s[k] !== rom_f(8'd0, 9'd1) ||
            prow_s[k] !== 8'd0 || pcol_s[k] !== 9'd1) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d valid=%b data=%h r=%0d c=%0d required 1 %h 0 1",
                   cyc, val_s[k], pdat_s[k], prow_s[k], pcol_s[k], rom_f(8'd0, 9'd1));
        end
      end
      if (mode == 1 && cyc >= 5 && cyc <= 8) begin
        checks++;
        if (rrow_s[k] !== 8'd0 || rcol_s[k] !== 9'd3) begin
          errors++;
          $display("FAIL stall_issue cyc=%0d rom=(%0d,%0d) required (0,3)",
                   cyc, rrow_s[k], rcol_s[k]);
        end
      end
      if (done_s[k] === 1'b1) begin
        checks++;
        if (idx !== n || busy_s[k] !== 1'b0 || val_s[k] !== 1'b0 ||
            cyc !== last_hs + 1) begin
          errors++;
          $display("FAIL done_pulse k=%0d cyc=%0d hs=%0d busy=%b valid=%b required hs=%0d cyc=%0d busy 0 valid 0",
                   k, cyc, idx, busy_s[k], val_s[k], n, last_hs + 1);
        end
        if (mode == 0) begin
          checks++;
          if (cyc !== 3 + n) begin
            errors++;
            $display("FAIL done_cycle k=%0d got %0d required %0d", k, cyc, 3 + n);
          end
        end
        fin = 1'b1;
      end else begin
        checks++;
        if (busy_s[k] !== 1'b1) begin
          errors++;
          $display("FAIL busy k=%0d cyc=%0d got %b required 1", k, cyc, busy_s[k]);
        end
        if (val_s[k] === 1'b1 && ready_s[k] === 1'b1) begin
          er = 8'(idx / w);
          ec = 9'(idx % w);
          checks++;
          if (idx >= n || prow_s[k] !== er || pcol_s[k] !== ec ||
              pdat_s[k] !== rom_f(er, ec) ||
              sof_s[k] !== (idx == 0) || eol_s[k] !== (int'(ec) == w - 1) ||
              eof_s[k] !== (idx == n - 1)) begin
            errors++;
            $display("FAIL pixel k=%0d idx=%0d got r=%0d c=%0d d=%h s/l/f=%b%b%b required r=%0d c=%0d d=%h s/l/f=%b%b%b",
                     k, idx, prow_s[k], pcol_s[k], pdat_s[k], sof_s[k], eol_s[k], eof_s[k],
                     er, ec, rom_f(er, ec), idx == 0, int'(ec) == w - 1, idx == n - 1);
          end
          if (mode == 0) begin
            checks++;
            if (cyc !== 3 + idx) begin
              errors++;
              $display("FAIL pixel_cycle k=%0d idx=%0d got %0d required %0d",
                       k, idx, cyc, 3 + idx);
            end
          end
          idx++;
          last_hs = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout k=%0d handshakes=%0d required %0d then done", k, idx, n);
    end
    start_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b0;
      start_s[k] = 1'b0;
      ready_s[k] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_s[k], done_s[k], rrow_s[k], rcol_s[k], pdat_s[k], prow_s[k],
           pcol_s[k], sof_s[k], eol_s[k], eof_s[k], val_s[k]} !== '0) begin
        errors++;
        $display("FAIL reset_state k=%0d busy=%b done=%b rom=(%0d,%0d) valid=%b data=%h required all 0",
                 k, busy_s[k], done_s[k], rrow_s[k], rcol_s[k], val_s[k], pdat_s[k]);
      end
      rst_s[k] = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (val_s[0] === 1'b1 && prow_s[0] === 8'd1 && pcol_s[0] === 9'd2) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach got no pixel (1,2) required valid (1,2)");
    end
    rst_s[0] = 1'b0;
    @(negedge clk);
    rst_s[0] = 1'b1;
    checks++;
    if ({busy_s[0], done_s[0], rrow_s[0], rcol_s[0], pdat_s[0], prow_s[0],
         pcol_s[0], sof_s[0], eol_s[0], eof_s[0], val_s[0]} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state busy=%b rom=(%0d,%0d) valid=%b pix=(%0d,%0d) data=%h required all 0",
               busy_s[0], rrow_s[0], rcol_s[0], val_s[0], prow_s[0], pcol_s[0], pdat_s[0]);
    end
    @(negedge clk);
    run_frame(0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    run_frame(0, 0, 1'b0);
    @(negedge clk);
    run_frame(0, 1, 1'b0);
    @(negedge clk);
    run_frame(1, 2, 1'b0);
    @(negedge clk);
    run_frame(0, 0, 1'b1);
    @(negedge clk);
    run_frame(0, 0, 1'b0);
    test_mid_reset();
    @(negedge clk);
    run_frame(2, 0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
